// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus the memory-side bus of the arbiter.
// master: the arbiter's view. slave: requesters and memory.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] adr0;
  logic [DW-1:0] wd0;
  logic          done0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] adr1;
  logic [DW-1:0] wd1;
  logic          done1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  req0, we0, adr0, wd0, req1, we1, adr1, wd1, mem_rdata,
    output done0, done1, rdata, busy, mem_en, mem_we, mem_adr, mem_wd
  );

  modport slave (
    output req0, we0, adr0, wd0, req1, we1, adr1, wd1, mem_rdata,
    input  done0, done1, rdata, busy, mem_en, mem_we, mem_adr, mem_wd
  );
endinterface

// File: rtl/arb_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the requester that
// did not own the memory last time wins.
module arb_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 && req1) ? ~last_owner : req1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises requester 0 (core) and requester 1 (DMA/loader) onto one
// synchronous memory with a fixed read latency; all outputs registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.master bus
);

  arb_state_t    state;
  arb_state_t    state_n;
  logic          owner;
  logic          last_owner;
  logic          we_q;
  logic [3:0]    cnt;
  logic          pick_valid;
  logic          pick_winner;
  logic          win_we;
  logic [AW-1:0] win_adr;
  logic [DW-1:0] win_wd;

  arb_rr_pick u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    win_we  = pick_winner ? bus.we1  : bus.we0;
    win_adr = pick_winner ? bus.adr1 : bus.adr0;
    win_wd  = pick_winner ? bus.wd1  : bus.wd0;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (pick_valid) state_n = ACCESS;
      ACCESS:  state_n = we_q ? DONE : WAIT;
      WAIT:    if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWNER_CPU;
      last_owner <= OWNER_DMA;
      we_q       <= 1'b0;
      cnt        <= '0;
      bus.busy    <= 1'b0;
      bus.done0   <= 1'b0;
      bus.done1   <= 1'b0;
      bus.mem_en  <= 1'b0;
      bus.mem_we  <= 1'b0;
      bus.mem_adr <= '0;
      bus.mem_wd  <= '0;
      bus.rdata   <= '0;
    end else begin
      state      <= state_n;
      bus.busy   <= (state_n != IDLE);
      bus.mem_en <= (state_n == ACCESS);
      bus.mem_we <= (state_n == ACCESS) && win_we;
      bus.done0  <= (state_n == DONE) && (owner == OWNER_CPU);
      bus.done1  <= (state_n == DONE) && (owner == OWNER_DMA);

      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner       <= pick_winner;
            we_q        <= win_we;
            bus.mem_adr <= win_adr;
            bus.mem_wd  <= win_wd;
          end
        end
        ACCESS: begin
          if (!we_q) cnt <= 4'(RD_LATENCY - 1);
        end
        WAIT: begin
          if (cnt == '0) bus.rdata <= bus.mem_rdata;
          else           cnt <= cnt - 4'd1;
        end
        DONE: begin
          last_owner <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 3-cycle-latency behavioural memory.
module tb_mem_arbiter;

  localparam int unsigned RDL = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .RD_LATENCY(RDL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [0:RDL-1];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_adr[9:2]] <= bus.mem_wd;
    rd_pipe[0] <= bus.mem_en ? mem[bus.mem_adr[9:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_rdata = rd_pipe[RDL-1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int cyc, output logic d0, output logic d1);
    cyc = 0; d0 = 1'b0; d1 = 1'b0;
    while (cyc < limit && !(d0 || d1)) begin
      tick();
      cyc++;
      d0 = bus.done0;
      d1 = bus.done1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({bus.busy, bus.mem_en, bus.mem_we, bus.done0, bus.done1} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000",
                         {bus.busy, bus.mem_en, bus.mem_we, bus.done0, bus.done1});
    end
    checks++;
    if ({bus.mem_adr, bus.mem_wd, bus.rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data adr %h wd %h rdata %h want 0", bus.mem_adr, bus.mem_wd, bus.rdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy %b mem_en %b want 0 0", bus.busy, bus.mem_en);
    end
  endtask

  task automatic test_single_write;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 32'h40; bus.wd0 = 32'hDEADBEEF;
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.busy, bus.done0, bus.done1} !== 5'b11100) begin
      errors++; $display("FAIL wr_access en/we/busy/d0/d1 got %b want 11100",
                         {bus.mem_en, bus.mem_we, bus.busy, bus.done0, bus.done1});
    end
    checks++;
    if (bus.mem_adr !== 32'h40 || bus.mem_wd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_bus adr %h wd %h want 00000040 deadbeef", bus.mem_adr, bus.mem_wd);
    end
    tick();
    checks++;
    if ({bus.done0, bus.done1, bus.mem_en, bus.mem_we} !== 4'b1000) begin
      errors++; $display("FAIL wr_done d0/d1/en/we got %b want 1000",
                         {bus.done0, bus.done1, bus.mem_en, bus.mem_we});
    end
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.done0 !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL wr_idle done0 %b busy %b want 0 0", bus.done0, bus.busy);
    end
    checks++;
    if (mem[8'h10] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_memory got %h want deadbeef", mem[8'h10]);
    end
  endtask

  task automatic test_single_read;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 32'h40; bus.wd1 = 32'h0;
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_we} !== 2'b10 || bus.mem_adr !== 32'h40) begin
      errors++; $display("FAIL rd_access en/we %b adr %h want 10 00000040", {bus.mem_en, bus.mem_we}, bus.mem_adr);
    end
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++;
      if ({bus.mem_en, bus.done0, bus.done1, bus.busy} !== 4'b0001) begin
        errors++; $display("FAIL rd_wait_t%0d en/d0/d1/busy got %b want 0001", i,
                           {bus.mem_en, bus.done0, bus.done1, bus.busy});
      end
    end
    tick();
    checks++;
    if (bus.done1 !== 1'b1 || bus.done0 !== 1'b0 || bus.rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_done d1 %b d0 %b rdata %h want 1 0 deadbeef", bus.done1, bus.done0, bus.rdata);
    end
    bus.req1 = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done1 !== 1'b0) begin
      errors++; $display("FAIL rd_idle busy %b done1 %b want 0 0", bus.busy, bus.done1);
    end
  endtask

  task automatic test_tie(input string tag);
    int   cyc;
    logic d0, d1;
    logic exp1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'h100;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 32'h200;
    for (int k = 0; k < 4; k++) begin
      exp1 = (k % 2) == 1;
      wait_done(12, cyc, d0, d1);
      checks++;
      if (cyc !== ((k == 0) ? 5 : 6)) begin
        errors++; $display("FAIL %s_latency_%0d got %0d cycles want %0d", tag, k, cyc, (k == 0) ? 5 : 6);
      end
      checks++;
      if ({d0, d1} !== {~exp1, exp1}) begin
        errors++; $display("FAIL %s_owner_%0d done0/done1 got %b want %b", tag, k, {d0, d1}, {~exp1, exp1});
      end
      checks++;
      if (bus.rdata !== (exp1 ? 32'h22222222 : 32'h11111111)) begin
        errors++; $display("FAIL %s_rdata_%0d got %h want %h", tag, k, bus.rdata,
                           exp1 ? 32'h22222222 : 32'h11111111);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 32'h40; bus.wd0 = 32'hA5A5A5A5;
    tick();
    tick();
    checks++;
    if (bus.done0 !== 1'b1) begin
      errors++; $display("FAIL b2b_first_done got %b want 1", bus.done0);
    end
    bus.adr0 = 32'h44; bus.wd0 = 32'h5A5A5A5A;
    tick();
    checks++;
    if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_gap mem_en %b busy %b want 0 0", bus.mem_en, bus.busy);
    end
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_we} !== 2'b11 || bus.mem_adr !== 32'h44 || bus.mem_wd !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL b2b_second en/we %b adr %h wd %h want 11 00000044 5a5a5a5a",
                         {bus.mem_en, bus.mem_we}, bus.mem_adr, bus.mem_wd);
    end
    tick();
    checks++;
    if (bus.done0 !== 1'b1 || bus.done1 !== 1'b0) begin
      errors++; $display("FAIL b2b_second_done d0 %b d1 %b want 1 0", bus.done0, bus.done1);
    end
    bus.req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read;
    int seen;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 32'h80;
    tick();
    checks++;
    if (bus.mem_en !== 1'b1) begin
      errors++; $display("FAIL rst_mid_access mem_en got %b want 1", bus.mem_en);
    end
    tick();
    reset = 1'b1; bus.req1 = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.mem_en, bus.mem_we, bus.done0, bus.done1} !== 5'b0 || bus.rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid_clear flags %b rdata %h want 00000 00000000",
                         {bus.busy, bus.mem_en, bus.mem_we, bus.done0, bus.done1}, bus.rdata);
    end
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done0 || bus.done1 || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_mid_no_done activity cycles got %0d want 0", seen);
    end
  endtask

  task automatic test_protocol;
    int   cyc;
    logic d0, d1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'h100;
    tick();
    tick();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 32'h200;
    tick();
    bus.req1 = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.done0, bus.done1} !== 2'b10 || bus.rdata !== 32'h11111111) begin
      errors++; $display("FAIL proto_a_done d0/d1 %b rdata %h want 10 11111111", {bus.done0, bus.done1}, bus.rdata);
    end
    bus.req0 = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL proto_a_ignored mem_en %b busy %b want 0 0", bus.mem_en, bus.busy);
    end

    bus.req0 = 1'b1;
    tick();
    tick();
    bus.req1 = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({bus.done0, bus.done1} !== 2'b10 || bus.rdata !== 32'h11111111) begin
      errors++; $display("FAIL proto_b_done0 d0/d1 %b rdata %h want 10 11111111", {bus.done0, bus.done1}, bus.rdata);
    end
    bus.req0 = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_adr !== 32'h200) begin
      errors++; $display("FAIL proto_b_grant1 mem_en %b adr %h want 1 00000200", bus.mem_en, bus.mem_adr);
    end
    wait_done(10, cyc, d0, d1);
    checks++;
    if (cyc !== 4 || {d0, d1} !== 2'b01 || bus.rdata !== 32'h22222222) begin
      errors++; $display("FAIL proto_b_done1 cycles %0d d0/d1 %b rdata %h want 4 01 22222222", cyc, {d0, d1}, bus.rdata);
    end
    bus.req1 = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.adr0 = '0; bus.wd0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.adr1 = '0; bus.wd1 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h11111111;
    mem[8'h80] = 32'h22222222;
    #1;
    test_reset();
    test_single_write();
    test_single_read();
    test_tie("tie");
    test_back_to_back();
    test_reset_mid_read();
    test_tie("tie_after_reset");
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
